// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: two-requester (icache/dcache) round-robin arbiter that turns
// whole-line refill/write-back requests into single-word memory beats.
// Reads issue one beat and then wait for its response before the next beat.
// Writes stream their beats back to back with no response phase.
module cpu_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                                   clock,
    input  logic                                   reset,
    // requester side (index 0 = icache, 1 = dcache)
    input  logic [1:0]                             rq_valid,
    output logic [1:0]                             rq_ready,
    input  logic [1:0]                             rq_write,
    input  logic [1:0][ADDR_WIDTH-1:0]             rq_addr,
    input  logic [1:0][WORD_WIDTH*LINE_WORDS-1:0]  rq_wdata,
    output logic [1:0]                             rs_valid,
    output logic [WORD_WIDTH*LINE_WORDS-1:0]       rs_rdata,
    // memory side, one word per beat
    output logic                                   mem_req_valid,
    input  logic                                   mem_req_ready,
    output logic                                   mem_req_write,
    output logic [ADDR_WIDTH-1:0]                  mem_req_addr,
    output logic [WORD_WIDTH-1:0]                  mem_req_wdata,
    input  logic                                   mem_resp_valid,
    input  logic [WORD_WIDTH-1:0]                  mem_resp_data
);

    localparam int LINE_BITS      = WORD_WIDTH * LINE_WORDS;
    localparam int BYTES_PER_WORD = WORD_WIDTH / 8;
    localparam int OFFSET_BITS    = $clog2(LINE_WORDS * BYTES_PER_WORD);
    localparam int BEAT_SHIFT     = $clog2(BYTES_PER_WORD);
    localparam int BEAT_W         = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic                    owner_q, owner_d;
    logic                    last_grant_q, last_grant_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LINE_BITS-1:0]    wdata_q, wdata_d;
    logic [WORD_WIDTH-1:0]   line_q [LINE_WORDS];
    logic [WORD_WIDTH-1:0]   line_d [LINE_WORDS];
    logic [LINE_BITS-1:0]    rdata_q, rdata_d;

    logic                    grant_valid;
    logic                    grant_idx;
    logic                    last_beat;
    logic [WORD_WIDTH-1:0]   wdata_words [LINE_WORDS];
    logic                    unused_offset_bits;

    // Arbitration: a lone requester wins; on a tie the one not served last wins.
    assign grant_valid = |rq_valid;
    assign grant_idx   = (&rq_valid) ? ~last_grant_q : rq_valid[1];

    assign last_beat = (beat_q == BEAT_W'(LINE_WORDS - 1));

    // The in-line byte offset of the request address is discarded on purpose.
    assign unused_offset_bits = ^{rq_addr[0][OFFSET_BITS-1:0], rq_addr[1][OFFSET_BITS-1:0]};

    // Per-requester handshake and completion decode.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign rq_ready[gi] = (state_q == IDLE) && rq_valid[gi] && (grant_idx == 1'(gi));
            assign rs_valid[gi] = (state_q == DONE) && (owner_q == 1'(gi));
        end
    endgenerate

    // Split the latched write line into addressable words for beat selection.
    generate
        for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_wword
            assign wdata_words[gi] = wdata_q[gi*WORD_WIDTH +: WORD_WIDTH];
        end
    endgenerate

    // The line base has its offset bits cleared, so OR-ing the beat offset in
    // is the same as adding it.
    assign mem_req_write = write_q;
    assign mem_req_addr  = addr_q | (ADDR_WIDTH'(beat_q) << BEAT_SHIFT);
    assign mem_req_wdata = wdata_words[beat_q];
    assign rs_rdata      = rdata_q;

    // Next-state logic: request capture, beat sequencing and completion.
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        write_d       = write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        line_d        = line_q;
        rdata_d       = rdata_q;
        mem_req_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_idx;
                    write_d = rq_write[grant_idx];
                    addr_d  = {rq_addr[grant_idx][ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    wdata_d = rq_wdata[grant_idx];
                    beat_d  = '0;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    if (write_q) begin
                        if (last_beat) begin
                            beat_d  = '0;
                            state_d = DONE;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end else begin
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                if (mem_resp_valid) begin
                    line_d[beat_q] = mem_resp_data;
                    if (last_beat) begin
                        // Publish the completed line only now, so rs_rdata
                        // keeps the previous refill while this one fills.
                        for (int k = 0; k < LINE_WORDS; k++) begin
                            rdata_d[k*WORD_WIDTH +: WORD_WIDTH] = line_d[k];
                        end
                        beat_d  = '0;
                        state_d = DONE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end

            DONE: begin
                last_grant_d = owner_q;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            for (int k = 0; k < LINE_WORDS; k++) begin
                line_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            line_q       <= line_d;
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: scoreboard of expected memory beats and
// completions, filled when a request is driven and drained by a monitor.
module tb_cpu_mem_arbiter;

    localparam int AW = 32;
    localparam int WW = 32;
    localparam int LW = 4;
    localparam int LB = WW * LW;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [1:0]           rq_valid;
    logic [1:0]           rq_ready;
    logic [1:0]           rq_write;
    logic [1:0][AW-1:0]   rq_addr;
    logic [1:0][LB-1:0]   rq_wdata;
    logic [1:0]           rs_valid;
    logic [LB-1:0]        rs_rdata;
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic                 mem_req_write;
    logic [AW-1:0]        mem_req_addr;
    logic [WW-1:0]        mem_req_wdata;
    logic                 mem_resp_valid;
    logic [WW-1:0]        mem_resp_data;

    cpu_mem_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .LINE_WORDS(LW)) dut (
        .clock          (clock),
        .reset          (reset),
        .rq_valid       (rq_valid),
        .rq_ready       (rq_ready),
        .rq_write       (rq_write),
        .rq_addr        (rq_addr),
        .rq_wdata       (rq_wdata),
        .rs_valid       (rs_valid),
        .rs_rdata       (rs_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [WW-1:0] wdata;
    } beat_t;

    typedef struct {
        int            owner;
        logic [LB-1:0] rdata;
        int            lat;
    } cmp_t;

    beat_t beat_q[$];
    cmp_t  cmp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // memory model / monitor state
    logic          resp_pending = 1'b0;
    logic [WW-1:0] resp_data_pend = '0;
    logic          stray_req = 1'b0;
    logic [1:0]    stall_beat = 2'd0;
    int            stall_left = 0;
    logic [LB-1:0] model_line = '0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
        if (a[AW-1:4] == 28'h100) return 32'hA0 + 32'(a[3:2]);
        return {16'hD000, a[15:0]};
    endfunction

    // Expected beats and completion for one transaction, in service order.
    task automatic push_txn(input int owner, input logic write, input logic [AW-1:0] addr,
                            input logic [LB-1:0] wdata, input int lat);
        beat_t         b;
        cmp_t          c;
        logic [AW-1:0] base;
        logic [LB-1:0] line;
        base = addr & ~32'hF;
        line = '0;
        for (int k = 0; k < LW; k++) begin
            b.write = write;
            b.addr  = base + 32'(4 * k);
            b.wdata = write ? wdata[k*WW +: WW] : '0;
            beat_q.push_back(b);
            line[k*WW +: WW] = mem_word(base + 32'(4 * k));
        end
        if (!write) model_line = line;
        c.owner = owner;
        c.rdata = model_line;
        c.lat   = lat;
        cmp_q.push_back(c);
    endtask

    // One clock: sample handshakes before the edge, then drive the memory side.
    task automatic step(output logic [1:0] acc);
        @(negedge clock);
        acc = rq_valid & rq_ready;
        @(posedge clock);
        #2;
        mem_resp_valid = resp_pending | stray_req;
        mem_resp_data  = resp_pending ? resp_data_pend : 32'hDEADBEEF;
        if (stall_left > 0 && mem_req_valid && mem_req_addr[3:2] == stall_beat) begin
            mem_req_ready = 1'b0;
            stall_left--;
        end else begin
            mem_req_ready = 1'b1;
        end
    endtask

    task automatic wait_drain(input string name);
        logic [1:0] acc;
        int         budget;
        budget = 0;
        while ((cmp_q.size() != 0 || beat_q.size() != 0) && budget < 200) begin
            step(acc);
            budget++;
        end
        n_cmp++;
        if (cmp_q.size() != 0 || beat_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: pending beats=%0d completions=%0d required 0/0",
                     name, beat_q.size(), cmp_q.size());
        end
    endtask

    task automatic run_one(input int owner, input logic write, input logic [AW-1:0] addr,
                           input logic [LB-1:0] wdata, input int lat, input string name);
        logic [1:0] acc;
        int         budget;
        push_txn(owner, write, addr, wdata, lat);
        rq_valid[owner] = 1'b1;
        rq_write[owner] = write;
        rq_addr[owner]  = addr;
        rq_wdata[owner] = wdata;
        budget = 0;
        acc = 2'b00;
        while (!acc[owner] && budget < 50) begin
            step(acc);
            budget++;
        end
        rq_valid[owner] = 1'b0;
        n_cmp++;
        if (!acc[owner]) begin
            n_err++;
            $display("FAIL %s_accept: rq_ready never seen, required acceptance within 50 cycles", name);
        end
        wait_drain(name);
    endtask

    task automatic do_reset();
        logic [1:0] acc;
        reset = 1'b1;
        rq_valid = 2'b00;
        stall_left = 0;
        step(acc);
        step(acc);
        reset = 1'b0;
        model_line = '0;
    endtask

    // Monitor: checks beats, stalls, completions and ready-while-busy.
    initial begin : monitor
        logic  busy;
        int    accept_cyc;
        logic  stalled_prev;
        beat_t stall_cmd;
        beat_t eb;
        cmp_t  ec;
        busy = 1'b0;
        accept_cyc = 0;
        stalled_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                beat_q.delete();
                cmp_q.delete();
                busy = 1'b0;
                resp_pending = 1'b0;
                stalled_prev = 1'b0;
            end else begin
                if (busy && rq_valid != 2'b00) begin
                    n_cmp++;
                    if (rq_ready !== 2'b00) begin
                        n_err++;
                        $display("FAIL ready_while_busy: rq_ready=%b required 00", rq_ready);
                    end
                end
                if ((rq_valid & rq_ready) != 2'b00) begin
                    busy = 1'b1;
                    accept_cyc = cyc;
                end
                if (mem_req_valid && !mem_req_ready) begin
                    if (stalled_prev) begin
                        n_cmp++;
                        if (mem_req_addr !== stall_cmd.addr || mem_req_write !== stall_cmd.write ||
                            mem_req_wdata !== stall_cmd.wdata) begin
                            n_err++;
                            $display("FAIL stall_stable: cmd w=%b a=%h d=%h required w=%b a=%h d=%h",
                                     mem_req_write, mem_req_addr, mem_req_wdata,
                                     stall_cmd.write, stall_cmd.addr, stall_cmd.wdata);
                        end
                    end
                    stall_cmd.write = mem_req_write;
                    stall_cmd.addr  = mem_req_addr;
                    stall_cmd.wdata = mem_req_wdata;
                    stalled_prev = 1'b1;
                end else begin
                    stalled_prev = 1'b0;
                end
                resp_pending = 1'b0;
                if (mem_req_valid && mem_req_ready) begin
                    n_cmp++;
                    if (beat_q.size() == 0) begin
                        n_err++;
                        $display("FAIL beat_unexpected: w=%b a=%h required no beat", mem_req_write, mem_req_addr);
                    end else begin
                        eb = beat_q.pop_front();
                        if (mem_req_addr !== eb.addr || mem_req_write !== eb.write ||
                            (eb.write && mem_req_wdata !== eb.wdata)) begin
                            n_err++;
                            $display("FAIL beat: w=%b a=%h d=%h required w=%b a=%h d=%h",
                                     mem_req_write, mem_req_addr, mem_req_wdata, eb.write, eb.addr, eb.wdata);
                        end
                    end
                    if (!mem_req_write) begin
                        resp_pending   = 1'b1;
                        resp_data_pend = mem_word(mem_req_addr);
                    end
                end
                if (rs_valid != 2'b00) begin
                    n_cmp++;
                    if (cmp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL rs_unexpected: rs_valid=%b required 00", rs_valid);
                    end else begin
                        ec = cmp_q.pop_front();
                        if (rs_valid !== (2'b01 << ec.owner)) begin
                            n_err++;
                            $display("FAIL rs_owner: rs_valid=%b required %b", rs_valid, 2'b01 << ec.owner);
                        end
                        n_cmp++;
                        if (rs_rdata !== ec.rdata) begin
                            n_err++;
                            $display("FAIL rs_rdata: got %h required %h", rs_rdata, ec.rdata);
                        end
                        n_cmp++;
                        if (cyc - accept_cyc != ec.lat) begin
                            n_err++;
                            $display("FAIL rs_latency: got %0d required %0d", cyc - accept_cyc, ec.lat);
                        end
                        $display("txn done: owner=%0d latency=%0d rdata=%h", ec.owner, cyc - accept_cyc, rs_rdata);
                    end
                    busy = 1'b0;
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        rq_valid = 2'b00;
        rq_write = 2'b00;
        rq_addr = '0;
        rq_wdata = '0;
        mem_req_ready = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data = '0;
        repeat (2) @(posedge clock);
        #2;
        rq_valid = 2'b11;
        @(negedge clock);
        n_cmp++;
        if (rq_ready !== 2'b01) begin
            n_err++;
            $display("FAIL reset_tie_ready: rq_ready=%b required 01", rq_ready);
        end
        @(posedge clock);
        #2;
        rq_valid = 2'b00;
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (mem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mem_req_valid: got %b required 0", mem_req_valid);
        end
        n_cmp++;
        if (rs_valid !== 2'b00) begin
            n_err++;
            $display("FAIL reset_rs_valid: got %b required 00", rs_valid);
        end
        n_cmp++;
        if (rs_rdata !== '0) begin
            n_err++;
            $display("FAIL reset_rs_rdata: got %h required 0", rs_rdata);
        end
        n_cmp++;
        if (rq_ready !== 2'b00) begin
            n_err++;
            $display("FAIL reset_rq_ready: got %b required 00", rq_ready);
        end
        @(posedge clock);
        #2;
    endtask

    task automatic test_read_refill();
        logic [LB-1:0] exp_line;
        exp_line = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        run_one(0, 1'b0, 32'h1004, '0, 9, "refill");
        n_cmp++;
        if (rs_rdata !== exp_line) begin
            n_err++;
            $display("FAIL refill_hold: rs_rdata=%h required %h", rs_rdata, exp_line);
        end
    endtask

    task automatic test_tie();
        logic [1:0]    acc;
        logic [LB-1:0] wline;
        int            n0;
        logic          done1;
        int            order;
        int            budget;
        do_reset();
        wline = {32'h44, 32'h33, 32'h22, 32'h11};
        push_txn(0, 1'b0, 32'h4010, '0, 9);
        push_txn(1, 1'b0, 32'h5020, '0, 9);
        push_txn(0, 1'b1, 32'h6000, wline, 5);
        rq_write = 2'b00;
        rq_addr[0] = 32'h4010;
        rq_addr[1] = 32'h5020;
        rq_valid = 2'b11;
        n0 = 0;
        done1 = 1'b0;
        order = 0;
        budget = 0;
        while ((n0 < 2 || !done1) && budget < 100) begin
            step(acc);
            budget++;
            if (acc == 2'b01) order = order * 4 + 1;
            if (acc == 2'b10) order = order * 4 + 2;
            if (acc[0]) begin
                if (n0 == 0) begin
                    rq_write[0] = 1'b1;
                    rq_addr[0]  = 32'h6000;
                    rq_wdata[0] = wline;
                end else begin
                    rq_valid[0] = 1'b0;
                end
                n0++;
            end
            if (acc[1]) begin
                rq_valid[1] = 1'b0;
                done1 = 1'b1;
            end
        end
        rq_valid = 2'b00;
        n_cmp++;
        if (order != 25) begin
            n_err++;
            $display("FAIL tie_order: grant code %0d required 25 (rq0, rq1, rq0)", order);
        end
        wait_drain("tie");
    endtask

    task automatic test_write_back();
        run_one(1, 1'b1, 32'h2000, {32'd4, 32'd3, 32'd2, 32'd1}, 5, "writeback");
    endtask

    task automatic test_backpressure();
        stall_beat = 2'd2;
        stall_left = 3;
        run_one(1, 1'b0, 32'h7008, '0, 12, "bp_read");
        stall_beat = 2'd1;
        stall_left = 3;
        run_one(0, 1'b1, 32'h7100, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 8, "bp_write");
    endtask

    task automatic test_random();
        int            owner;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LB-1:0] wd;
        for (int i = 0; i < 6; i++) begin
            owner = int'($urandom_range(0, 1));
            wr    = 1'($urandom_range(0, 1));
            addr  = $urandom;
            wd    = {$urandom, $urandom, $urandom, $urandom};
            run_one(owner, wr, addr, wd, wr ? 5 : 9, "random");
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] acc;
        int         budget;
        push_txn(0, 1'b0, 32'h3000, '0, 9);
        rq_write[0] = 1'b0;
        rq_addr[0]  = 32'h3000;
        rq_valid[0] = 1'b1;
        budget = 0;
        acc = 2'b00;
        while (!acc[0] && budget < 50) begin
            step(acc);
            budget++;
        end
        rq_valid[0] = 1'b0;
        while (beat_q.size() > 2 && budget < 100) begin
            step(acc);
            budget++;
        end
        n_cmp++;
        if (beat_q.size() != 2) begin
            n_err++;
            $display("FAIL rstmid_setup: beats left %0d required 2", beat_q.size());
        end
        reset = 1'b1;
        step(acc);
        reset = 1'b0;
        model_line = '0;
        n_cmp++;
        if (mem_req_valid !== 1'b0 || rs_valid !== 2'b00) begin
            n_err++;
            $display("FAIL rstmid_idle: mem_req_valid=%b rs_valid=%b required 0/00", mem_req_valid, rs_valid);
        end
        stray_req = 1'b1;
        step(acc);
        stray_req = 1'b0;
        step(acc);
        step(acc);
        n_cmp++;
        if (mem_req_valid !== 1'b0 || rs_valid !== 2'b00 || rs_rdata !== '0) begin
            n_err++;
            $display("FAIL rstmid_stray: mem_req_valid=%b rs_valid=%b rs_rdata=%h required 0/00/0",
                     mem_req_valid, rs_valid, rs_rdata);
        end
        run_one(1, 1'b0, 32'h3000, '0, 9, "after_reset");
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_read_refill();
        test_tie();
        test_write_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        n_cmp++;
        if (beat_q.size() != 0 || cmp_q.size() != 0) begin
            n_err++;
            $display("FAIL final_queues: beats=%0d completions=%0d required 0/0", beat_q.size(), cmp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
